// File: rtl/aor_key_loader_bist_if.sv
// Key-loader / BIST bus for the locked lower-part-OR adder.
// Carries the key stream, the adder operands and the run status.
interface aor_key_loader_bist_if;
  logic        key_load_i;
  logic        key_sdata_i;
  logic        key_svalid_i;
  logic [16:0] result_i;
  logic [15:0] add1_o;
  logic [15:0] add2_o;
  logic [31:0] keyinput_o;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [7:0]  fail_count_o;

  modport slave (
    input  key_load_i,
    input  key_sdata_i,
    input  key_svalid_i,
    input  result_i,
    output add1_o,
    output add2_o,
    output keyinput_o,
    output busy_o,
    output done_o,
    output pass_o,
    output fail_count_o
  );

  modport master (
    output key_load_i,
    output key_sdata_i,
    output key_svalid_i,
    output result_i,
    input  add1_o,
    input  add2_o,
    input  keyinput_o,
    input  busy_o,
    input  done_o,
    input  pass_o,
    input  fail_count_o
  );
endinterface

// File: rtl/aor_key_loader_bist.sv
// Serial key loader plus LFSR BIST for the locked lower-part-OR adder.
// The key is applied atomically; the adder is then checked against a golden model.
module aor_key_loader_bist #(
  parameter int          LOWER_BITS  = 4,
  parameter int          NUM_VECTORS = 16,
  parameter int          SETTLE_CYC  = 2,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  aor_key_loader_bist_if.slave  bus
);

  localparam int UW = 17 - LOWER_BITS;
  localparam int HW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_BIST,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [30:0]    sh_q;
  logic [4:0]     bcnt_q;
  logic [31:0]    lfsr_q;
  logic [HW-1:0]  hold_q;
  logic [15:0]    vcnt_q;
  logic [31:0]    key_q;
  logic [15:0]    add1_q;
  logic [15:0]    add2_q;
  logic           busy_q;
  logic           done_q;
  logic           pass_q;
  logic [7:0]     fail_q;

  logic [31:0]           sh_d;
  logic [31:0]           lfsr_d;
  logic [LOWER_BITS-1:0] lo_d;
  logic                  c_d;
  logic [UW-1:0]         up_d;
  logic [16:0]           gold_d;
  logic                  mis_d;
  logic [7:0]            fail_d;
  logic                  last_hold;
  logic                  last_vec;

  assign sh_d   = {sh_q, bus.key_sdata_i};
  assign lfsr_d = {lfsr_q[30:0],
                   lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

  // Golden model: OR in the low part, carry-in from the top low bits' AND
  assign lo_d   = add1_q[LOWER_BITS-1:0] | add2_q[LOWER_BITS-1:0];
  assign c_d    = add1_q[LOWER_BITS-1] & add2_q[LOWER_BITS-1];
  assign up_d   = UW'(add1_q[15:LOWER_BITS])
                + UW'(add2_q[15:LOWER_BITS])
                + UW'(c_d);
  assign gold_d = {up_d, lo_d};

  assign mis_d     = (bus.result_i != gold_d);
  assign fail_d    = (mis_d && (fail_q != 8'hFF)) ? fail_q + 8'd1 : fail_q;
  assign last_hold = (hold_q == HW'(SETTLE_CYC - 1));
  assign last_vec  = (vcnt_q == 16'(NUM_VECTORS - 1));

  // Controller FSM with all outputs registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bcnt_q  <= '0;
      lfsr_q  <= SEED;
      hold_q  <= '0;
      vcnt_q  <= '0;
      key_q   <= '0;
      add1_q  <= '0;
      add2_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.key_load_i) begin
            state_q <= S_SHIFT;
            sh_q    <= '0;
            bcnt_q  <= '0;
            lfsr_q  <= SEED;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
          end
        end
        S_SHIFT: begin
          if (bus.key_svalid_i) begin
            sh_q   <= sh_d[30:0];
            bcnt_q <= bcnt_q + 5'd1;
            if (bcnt_q == 5'd31) begin
              key_q   <= sh_d;
              state_q <= S_BIST;
              add1_q  <= lfsr_q[31:16];
              add2_q  <= lfsr_q[15:0];
              hold_q  <= '0;
              vcnt_q  <= '0;
            end
          end
        end
        S_BIST: begin
          if (last_hold) begin
            hold_q <= '0;
            fail_q <= fail_d;
            lfsr_q <= lfsr_d;
            if (last_vec) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_d == 8'd0);
            end else begin
              vcnt_q <= vcnt_q + 16'd1;
              add1_q <= lfsr_d[31:16];
              add2_q <= lfsr_d[15:0];
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.add1_o       = add1_q;
  assign bus.add2_o       = add2_q;
  assign bus.keyinput_o   = key_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.pass_o       = pass_q;
  assign bus.fail_count_o = fail_q;

endmodule

// File: doc/aor_key_loader_bist.md
Name: aor_key_loader_bist

Overview:
- Companion controller for the 32-bit-key locked lower-part-OR 16-bit adder.
- Receives the unlock key serially and presents it atomically on keyinput_o.
- Then drives LFSR operand vectors into the locked adder and checks its 17-bit result against an internal golden lower-part-OR model.
- Reports pass/fail and a mismatch count; sits between the key store and the locked netlist.

Parameters:
- LOWER_BITS, 4: width of the OR-approximated lower part (1..15).
- NUM_VECTORS, 16: number of BIST vectors per run (1..65535).
- SETTLE_CYC, 2: cycles operands are held before result_i is sampled (>=1).
- SEED, 32'h00000001: LFSR seed, non-zero.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- key_load_i  in  1  start pulse; honoured only in IDLE or DONE.
- key_sdata_i  in  1  serial key bit, MSB first.
- key_svalid_i  in  1  key_sdata_i valid this cycle.
- result_i  in  17  result from the locked adder.
- add1_o  out  16  operand A to the locked adder.
- add2_o  out  16  operand B to the locked adder.
- keyinput_o  out  32  key applied to the locked adder.
- busy_o  out  1  high in SHIFT or BIST.
- done_o  out  1  high in DONE.
- pass_o  out  1  valid while done_o; 1 when there were zero mismatches.
- fail_count_o  out  8  saturating mismatch count.

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - All outputs go to 0, including keyinput_o, add1_o, add2_o and fail_count_o.
  - Shift register and bit counter clear; LFSR loads SEED.
  - Reset asserted mid-operation aborts it with no residue.
- IDLE:
  - key_load_i=1 goes to SHIFT.
  - On entry to SHIFT: bit count=0, fail_count_o=0, done_o=0, pass_o=0, LFSR=SEED.
- SHIFT:
  - Each cycle with key_svalid_i=1: sh <= {sh[30:0], key_sdata_i}; count++.
  - Cycles with key_svalid_i=0 hold state; gaps are unbounded.
  - On the 32nd valid bit, keyinput_o <= {sh[30:0], key_sdata_i} on that edge, and state goes to BIST.
  - keyinput_o never shows a partial key.
  - keyinput_o holds its value until the next completed load or reset.
- BIST, per vector:
  - add1_o=lfsr[31:16], add2_o=lfsr[15:0], held for SETTLE_CYC cycles.
  - On the last hold cycle, result_i is compared with golden(add1_o, add2_o).
  - On mismatch, fail_count_o++, saturating at 255.
  - LFSR then advances as a Fibonacci LFSR: lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
  - The vector counter increments.
  - The first vector is SEED itself.
  - After NUM_VECTORS compares, state goes to DONE.
  - add1_o/add2_o keep the last vector value in DONE.
- Golden model (L=LOWER_BITS):
  - r[L-1:0] = a[L-1:0] | b[L-1:0].
  - c = a[L-1] & b[L-1].
  - r[16:L] = a[15:L] + b[15:L] + c, a zero-extended 17-L bit sum.
- DONE:
  - done_o=1, pass_o=(fail_count_o==0).
  - key_load_i restarts at SHIFT and clears done_o, pass_o and fail_count_o on entry.
  - keyinput_o keeps the old key until the new 32nd bit arrives.
- Busy and ignored inputs:
  - busy_o=1 in SHIFT and BIST.
  - key_load_i while busy is ignored.
  - key_svalid_i outside SHIFT is ignored.
- Simultaneous events:
  - key_load_i and key_svalid_i in the same IDLE cycle: that bit is not captured; shifting starts the next cycle.
- Latency:
  - Key: 1 edge after the 32nd valid bit.
  - Run: NUM_VECTORS*SETTLE_CYC cycles from BIST entry to DONE.

Test Plan:
1. Reset and idle: hold rst_ni=0, then release with inputs idle -> all outputs 0, busy_o=0, state IDLE. Then assert rst_ni=0 mid-SHIFT after 10 bits -> keyinput_o stays 0 and busy_o=0 immediately (async).
2. Key load: pulse key_load_i, then shift 32'h96DF0F1F MSB-first with random key_svalid_i gaps.
   - keyinput_o=32'h96DF0F1F exactly one edge after the 32nd valid bit.
   - keyinput_o stays 0 before that edge.
   - busy_o=1 throughout.
3. Pass run (defaults): bench drives result_i from a correct behavioural model.
   - First vector is add1_o=0000, add2_o=0001; its golden result is 17'h00001.
   - After 32 BIST cycles: done_o=1, pass_o=1, fail_count_o=0.
4. Golden arithmetic spot check: bench forces LFSR-equivalent operands 29AF/7A1B with LOWER_BITS=4 -> compare expects 17'h0A3CF. The golden output is never the exact sum 17'h0A3CA.
5. Stuck-at fault: result_i tied to 0 -> fail_count_o=16 and pass_o=0 (LFSR never zero, so golden is never 0). With NUM_VECTORS=300 -> fail_count_o=255, saturated.
6. Busy and restart:
   - key_load_i pulsed during BIST -> ignored; run length unchanged.
   - key_load_i in DONE -> done_o/pass_o/fail_count_o clear next cycle.
   - Old key is held until the new key completes.
